cnt_ctrl: RTL

Command-driven controller for the up/down counter. It sits on the control side of the counter's interface and drives `load_en`, `load` and `down`, while reading back `count` and `rollover`. It accepts "load a start value, then step N times in one direction" commands over a valid/ready handshake, and holds the counter steady between commands. It reports the final value and the number of wrap-arounds, and can optionally check the counter's output against a predicted value.

---
 rtl/cnt_ctrl_pkg.sv | 28 ++
 rtl/cnt_ctrl_chk.sv | 62 ++++++
 rtl/cnt_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cnt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cnt_ctrl_pkg
// Shared types for the counter command controller.
//   cnt_ctrl_state_t : controller FSM states (IDLE, LOAD, RUN, DONE)
//   cnt_ctrl_cmd_t   : latched command (start value, direction, step count)
//   CNT_CTRL_W       : counter / step-count width the command struct is sized by
// -----------------------------------------------------------------------------
package cnt_ctrl_pkg;

   // Width of the counter and of the step count. The controller's WIDTH
   // parameter defaults to this value and must match it, because the command
   // struct below is sized from it.
   localparam int unsigned CNT_CTRL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } cnt_ctrl_state_t;

   typedef struct packed {
      logic [CNT_CTRL_W-1:0] load;   // start value
      logic                  down;   // 1 = decrement
      logic [CNT_CTRL_W-1:0] steps;  // number of RUN cycles
   } cnt_ctrl_cmd_t;

endpackage

// File: rtl/cnt_ctrl_chk.sv
// -----------------------------------------------------------------------------
// cnt_ctrl_chk
// Predicts the counter value for the command in flight and flags any cycle in
// which the counter disagrees. The prediction is seeded in LOAD and stepped
// once per RUN cycle; count is compared in every RUN cycle and in DONE.
// Ports:
//   clk, rst        : clock, async active-high reset
//   state_i         : controller state register
//   accept_i        : a command is being accepted this cycle (clears err)
//   load_i, down_i  : latched command start value and direction
//   count_i         : counter value
//   err_o           : sticky mismatch flag
// -----------------------------------------------------------------------------
module cnt_ctrl_chk
   import cnt_ctrl_pkg::*;
#(
   parameter int WIDTH = CNT_CTRL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  cnt_ctrl_state_t  state_i,
   input  logic             accept_i,
   input  logic [WIDTH-1:0] load_i,
   input  logic             down_i,
   input  logic [WIDTH-1:0] count_i,
   output logic             err_o
);

   logic [WIDTH-1:0] exp_q, exp_d;
   logic             err_q, err_d;
   logic             mismatch;

   always_comb begin
      exp_d    = exp_q;
      mismatch = 1'b0;
      case (state_i)
         LOAD: exp_d = load_i;
         RUN: begin
            mismatch = (count_i != exp_q);
            exp_d    = down_i ? (exp_q - WIDTH'(1)) : (exp_q + WIDTH'(1));
         end
         DONE:    mismatch = (count_i != exp_q);
         default: exp_d = exp_q;
      endcase
   end

   // A new command wipes the previous verdict; otherwise errors accumulate.
   assign err_d = accept_i ? 1'b0 : (err_q | mismatch);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q <= '0;
         err_q <= 1'b0;
      end else begin
         exp_q <= exp_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/cnt_ctrl.sv
// -----------------------------------------------------------------------------
// cnt_ctrl
// Command-driven controller for an up/down counter. Accepts "load a start
// value, then step N times" commands over valid/ready, drives the counter's
// load_en/load/down, and reports the final value and wrap count. Between
// commands the counter is held by reloading its own value.
// Optional feature: define CNT_CTRL_CHECK_EN to build the prediction checker
// (cnt_ctrl_chk); without it err is tied low.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   cmd_valid/cmd_ready               : command handshake (ready only in IDLE)
//   cmd_load, cmd_down, cmd_steps     : command fields
//   load_en, load, down               : counter control
//   count, rollover                   : counter status
//   done                              : one-cycle completion pulse
//   final_count                       : count captured in the DONE cycle
//   wraps                             : saturating wrap count of last command
//   err                               : sticky prediction mismatch
// -----------------------------------------------------------------------------
module cnt_ctrl
   import cnt_ctrl_pkg::*;
#(
   parameter int WIDTH = CNT_CTRL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_load,
   input  logic             cmd_down,
   input  logic [WIDTH-1:0] cmd_steps,
   output logic             load_en,
   output logic [WIDTH-1:0] load,
   output logic             down,
   input  logic [WIDTH-1:0] count,
   input  logic             rollover,
   output logic             done,
   output logic [WIDTH-1:0] final_count,
   output logic [WIDTH-1:0] wraps,
   output logic             err
);

   cnt_ctrl_state_t  state_q, state_d;
   cnt_ctrl_cmd_t    cmd_q, cmd_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] wraps_q, wraps_d;
   logic [WIDTH-1:0] final_q, final_d;
   logic             accept;
   logic             wrap_hit;

   assign accept = (state_q == IDLE) && cmd_valid;

   // Up-count wraps when leaving all-ones; down-count wraps when leaving zero.
   assign wrap_hit = cmd_q.down ? (count == '0) : rollover;

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      rem_d   = rem_q;
      wraps_d = wraps_q;
      final_d = final_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = LOAD;
               cmd_d.load  = cmd_load;
               cmd_d.down  = cmd_down;
               cmd_d.steps = cmd_steps;
               wraps_d     = '0;
            end
         end
         LOAD: begin
            rem_d   = cmd_q.steps;
            state_d = (cmd_q.steps == '0) ? DONE : RUN;
         end
         RUN: begin
            if (wrap_hit && (wraps_q != '1))
               wraps_d = wraps_q + WIDTH'(1);
            rem_d = rem_q - WIDTH'(1);
            // rem_q counts the RUN cycles still to go including this one.
            if (rem_q == WIDTH'(1))
               state_d = DONE;
         end
         DONE: begin
            final_d = count;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         rem_q   <= '0;
         wraps_q <= '0;
         final_q <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         rem_q   <= rem_d;
         wraps_q <= wraps_d;
         final_q <= final_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   // Outside RUN the counter is told to reload its own value, which holds it.
   always_comb begin
      load_en   = 1'b1;
      load      = count;
      down      = 1'b0;
      cmd_ready = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: cmd_ready = 1'b1;
         LOAD: load = cmd_q.load;
         RUN: begin
            load_en = 1'b0;
            down    = cmd_q.down;
         end
         DONE:    done = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   assign final_count = final_q;
   assign wraps       = wraps_q;

`ifdef CNT_CTRL_CHECK_EN
   cnt_ctrl_chk #(
      .WIDTH (WIDTH)
   ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .state_i  (state_q),
      .accept_i (accept),
      .load_i   (cmd_q.load),
      .down_i   (cmd_q.down),
      .count_i  (count),
      .err_o    (err)
   );
`else
   assign err = 1'b0;
`endif

endmodule
